frame_unpack: RTL and testbench

- Sits directly downstream of the receive-side frame checker (header 8'hCC plus checksum).
- Takes the checker's valid-frame level flag and its registered 40-bit frame output, and detects each new valid frame exactly once.
- Extracts the three payload bytes, buffers them in a byte FIFO, and presents them as a valid/ready byte stream to the consumer (UART TX / display logic).
- Counts accepted and dropped frames.

---
 rtl/frame_unpack.sv | 138 +++++++++++++
 tb/tb_frame_unpack.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_unpack.sv
// Frame unpacker: edge-detects checker frames, splits the payload into
// bytes and streams them out through a byte FIFO.
module frame_unpack #(
  parameter int FIFO_AW = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_flag,
  input  logic [39:0]      frame_data,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int PW = FIFO_AW + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1) << FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPT,
    S_W0,
    S_W1,
    S_W2
  } state_t;

  state_t r_state, w_next;

  logic          r_vf_d;
  logic [23:0]   r_pay;
  logic          r_wr_en;
  logic [7:0]    r_wr_data;
  logic [PW-1:0] r_wp, r_rp;
  logic [7:0]    r_mem [2**FIFO_AW];
  logic          r_ovf;
  logic [CNT_W-1:0] r_fcnt, r_dcnt;

  logic          w_new;
  logic          w_empty, w_full;
  logic [PW-1:0] w_free;
  logic          w_rd, w_wr;
  logic          w_drop_capt, w_drop_busy;
  logic          w_wr_en;
  logic [7:0]    w_wr_data;
  logic          w_done;

  assign w_new   = valid_flag & ~r_vf_d;
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[FIFO_AW] != r_rp[FIFO_AW]) &&
                   (r_wp[FIFO_AW-1:0] == r_rp[FIFO_AW-1:0]);
  // Same-cycle reads are not credited: free space is a lower bound.
  assign w_free  = DEPTH - (r_wp - r_rp);
  assign w_rd    = m_valid & m_ready;
  assign w_wr    = r_wr_en & ~w_full;

  assign m_valid   = ~w_empty;
  assign m_data    = w_empty ? 8'h00 : r_mem[r_rp[FIFO_AW-1:0]];
  assign busy      = (r_state != S_IDLE);
  assign overflow  = r_ovf;
  assign frame_cnt = r_fcnt;
  assign drop_cnt  = r_dcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_drop_capt = 1'b0;
    w_drop_busy = w_new & busy;
    w_wr_en     = 1'b0;
    w_wr_data   = 8'h00;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_new) w_next = S_CAPT;
      S_CAPT: begin
        if (w_free >= PW'(3)) begin
          w_next = S_W0;
        end else begin
          w_next      = S_IDLE;
          w_drop_capt = 1'b1;
        end
      end
      S_W0: begin
        w_wr_en   = 1'b1;
        w_wr_data = r_pay[23:16];
        w_next    = S_W1;
      end
      S_W1: begin
        w_wr_en   = 1'b1;
        w_wr_data = r_pay[15:8];
        w_next    = S_W2;
      end
      S_W2: begin
        w_wr_en   = 1'b1;
        w_wr_data = r_pay[7:0];
        w_done    = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Writes are staged one cycle so the FIFO sees each byte after its W state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vf_d    <= 1'b0;
      r_pay     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_ovf     <= 1'b0;
      r_fcnt    <= '0;
      r_dcnt    <= '0;
    end else begin
      r_vf_d    <= valid_flag;
      r_wr_en   <= w_wr_en;
      r_wr_data <= w_wr_data;
      r_ovf     <= w_drop_capt | w_drop_busy;
      if (r_state == S_CAPT) r_pay <= frame_data[31:8];
      if (w_wr) r_wp <= r_wp + PW'(1);
      if (w_rd) r_rp <= r_rp + PW'(1);
      if (w_done) r_fcnt <= r_fcnt + CNT_W'(1);
      r_dcnt <= r_dcnt + CNT_W'(w_drop_capt) + CNT_W'(w_drop_busy);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp[FIFO_AW-1:0]] <= r_wr_data;
  end

endmodule

// File: tb/tb_frame_unpack.sv
// Bench for frame_unpack: scoreboard of expected bytes, counters and
// overflow pulses, at depth 4 so drops and pointer wrap are reachable.
module tb_frame_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_flag;
  logic [39:0] frame_data;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        overflow;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  frame_unpack #(.FIFO_AW(2), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .valid_flag(valid_flag),
    .frame_data(frame_data),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .busy(busy),
    .overflow(overflow),
    .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_ovf = 0;
  int exp_fc = 0;
  int exp_dc = 0;
  int ovf_base;
  logic [7:0] exp_q [$];
  logic       hv = 1'b0;
  logic [7:0] hd = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hv && m_valid) chk("hold", {24'd0, m_data}, {24'd0, hd});
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("extra", {24'd0, m_data}, 32'hFFFF_FFFF);
      else chk("data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
    end
    hv = m_valid & ~m_ready;
    hd = m_data;
    if (overflow) n_ovf++;
  end

  task automatic push3(input logic [23:0] p);
    exp_q.push_back(p[23:16]);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[7:0]);
  endtask

  task automatic send(input logic [23:0] p, input bit acc,
                      input int hi, input int gap);
    @(posedge clk); #1;
    valid_flag = 1'b1;
    @(posedge clk); #1;
    frame_data = {8'hCC, p, 8'h5A};
    if (acc) push3(p);
    for (int i = 2; i < hi; i++) begin
      @(posedge clk); #1;
    end
    valid_flag = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain", exp_q.size(), 0);
    repeat (4) @(posedge clk);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_fcnt"}, {16'd0, frame_cnt}, exp_fc);
    chk({tag, "_dcnt"}, {16'd0, drop_cnt}, exp_dc);
  endtask

  initial begin
    rst = 1'b1;
    valid_flag = 1'b0;
    frame_data = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, m_valid}, 0);
    chk("rst_data", {24'd0, m_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk_cnt("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: long level, latency check
    @(posedge clk); #1;
    valid_flag = 1'b1;
    push3(24'h112233);
    @(posedge clk); #1;
    frame_data = 40'hCC_11_22_33_99;
    @(negedge clk); chk("lat1", {31'd0, m_valid}, 0);
    @(negedge clk); chk("lat2", {31'd0, m_valid}, 0);
    @(negedge clk); chk("lat3", {31'd0, m_valid}, 0);
    @(negedge clk); chk("lat4", {31'd0, m_valid}, 1);
    repeat (16) @(posedge clk);
    #1 valid_flag = 1'b0;
    drain();
    exp_fc++;
    chk_cnt("t1");
    chk("t1_ovf", n_ovf, 0);

    // 2: full FIFO drops the second frame
    @(posedge clk); #1 m_ready = 1'b0;
    ovf_base = n_ovf;
    send(24'h123456, 1, 2, 6);
    send(24'hAABBCC, 0, 2, 6);
    exp_fc++;
    exp_dc++;
    chk_cnt("t2");
    chk("t2_ovf", n_ovf - ovf_base, 1);
    @(posedge clk); #1 m_ready = 1'b1;
    drain();

    // 3: backpressure toggling
    @(posedge clk); #1 m_ready = 1'b0;
    send(24'h010203, 1, 2, 6);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1 m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    drain();
    exp_fc++;
    chk_cnt("t3");

    // 4: second edge while in W0
    ovf_base = n_ovf;
    @(posedge clk); #1 valid_flag = 1'b1;
    push3(24'h445566);
    @(posedge clk); #1 valid_flag = 1'b0;
    frame_data = 40'hCC_44_55_66_00;
    @(posedge clk); #1 valid_flag = 1'b1;
    @(posedge clk); #1 valid_flag = 1'b0;
    frame_data = 40'hCC_77_88_99_00;
    repeat (8) @(posedge clk);
    drain();
    exp_fc++;
    exp_dc++;
    chk_cnt("t4");
    chk("t4_ovf", n_ovf - ovf_base, 1);

    // 5: reset during W1
    @(posedge clk); #1 valid_flag = 1'b1;
    @(posedge clk); #1 valid_flag = 1'b0;
    frame_data = 40'hCC_DE_AD_BE_00;
    @(posedge clk);
    @(posedge clk); #1;
    chk("t5_busy_pre", {31'd0, busy}, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_valid", {31'd0, m_valid}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    exp_fc = 0;
    exp_dc = 0;
    chk_cnt("t5");
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    send(24'h7E7F80, 1, 3, 6);
    drain();
    exp_fc++;
    chk_cnt("t5b");

    // 6: 100 back-to-back frames wrap the pointers
    ovf_base = n_ovf;
    for (int i = 0; i < 100; i++) begin
      send(24'($urandom), 1, 2, 6);
    end
    drain();
    exp_fc += 100;
    chk_cnt("t6");
    chk("t6_ovf", n_ovf - ovf_base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
